// File: rtl/bloco_controle.sv
// Control FSM for blocoOperativo: sequences resultado = K*(A+B) + C as X*A + X*B + C, then pulses done.
// Optional BC_STATE_OUT_EN exposes the raw state code on port estado.
module bloco_controle #(
    parameter logic H_ADD   = 1'b0,
    parameter logic H_MUL   = 1'b1,
    parameter int   STATE_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H,
    output logic       busy,
    output logic       done
`ifdef BC_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0] estado
`endif
);

    typedef enum logic [STATE_W-1:0] {
        IDLE   = STATE_W'(0),
        LOAD_X = STATE_W'(1),
        MUL_A  = STATE_W'(2),
        MUL_B  = STATE_W'(3),
        ADD_HS = STATE_W'(4),
        ADD_C  = STATE_W'(5),
        DONE   = STATE_W'(6)
    } state_t;

    state_t     state_reg;
    state_t     state_next;

    logic       lx_next;
    logic       lh_next;
    logic       ls_next;
    logic [1:0] m0_next;
    logic [1:0] m1_next;
    logic [1:0] m2_next;
    logic       h_next;
    logic       busy_next;
    logic       done_next;

    // Illegal encodings fall into the default arm and recover to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? LOAD_X : IDLE;
            LOAD_X:  state_next = MUL_A;
            MUL_A:   state_next = MUL_B;
            MUL_B:   state_next = ADD_HS;
            ADD_HS:  state_next = ADD_C;
            ADD_C:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and then registered, so they
    // line up exactly with the state they belong to.
    always_comb begin
        lx_next   = 1'b0;
        lh_next   = 1'b0;
        ls_next   = 1'b0;
        m0_next   = 2'b00;
        m1_next   = 2'b00;
        m2_next   = 2'b00;
        h_next    = H_ADD;
        busy_next = 1'b1;
        done_next = 1'b0;
        case (state_next)
            LOAD_X: begin
                lx_next = 1'b1;
            end
            MUL_A: begin
                m0_next = 2'b01;
                h_next  = H_MUL;
                lh_next = 1'b1;
            end
            MUL_B: begin
                m0_next = 2'b10;
                h_next  = H_MUL;
                ls_next = 1'b1;
            end
            ADD_HS: begin
                m1_next = 2'b10;
                m2_next = 2'b11;
                ls_next = 1'b1;
            end
            ADD_C: begin
                m0_next = 2'b11;
                m2_next = 2'b10;
                ls_next = 1'b1;
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            LX        <= 1'b0;
            LH        <= 1'b0;
            LS        <= 1'b0;
            M0        <= 2'b00;
            M1        <= 2'b00;
            M2        <= 2'b00;
            H         <= H_ADD;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            LX        <= lx_next;
            LH        <= lh_next;
            LS        <= ls_next;
            M0        <= m0_next;
            M1        <= m1_next;
            M2        <= m2_next;
            H         <= h_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

`ifdef BC_STATE_OUT_EN
    assign estado = state_reg;
`endif

endmodule
